// File: rtl/macrocell_sop.sv
// CPLD-style macrocell: serially loaded shadow configuration, committed atomically
// into an active sum-of-products array feeding a D/T register or a combinational bypass.
module macrocell_sop #(
  parameter int num_input_signals = 88,
  parameter int num_product_terms = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cfg_shift_en,
  input  logic                         cfg_data_in,
  output logic                         cfg_data_out,
  input  logic                         cfg_commit,
  output logic                         configured,
  output logic                         cfg_error,
  input  logic                         clock_enable,
  input  logic [num_input_signals-1:0] input_signals,
  output logic [num_product_terms-1:0] term_out,
  output logic                         macrocell_out
);

  localparam int N          = num_input_signals;
  localparam int P          = num_product_terms;
  localparam int CFG_BITS   = P * (N + 1) + 3;
  localparam int CNT_W      = $clog2(CFG_BITS + 2);
  localparam int BIT_INVERT = CFG_BITS - 3;
  localparam int BIT_TMODE  = CFG_BITS - 2;
  localparam int BIT_BYPASS = CFG_BITS - 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(CFG_BITS + 1);

  typedef enum logic {
    UNCONFIGURED = 1'b0,
    CONFIGURED   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    bitCount_q, bitCount_d;
  logic                cfgError_q, cfgError_d;
  logic                mcReg_q, mcReg_d;

  logic         commitValid;
  logic         commitBad;
  logic [P-1:0] termRaw;
  logic         sumOut;
  logic         isConfigured;

  // Shift takes precedence: a commit is only looked at on a cycle with no shift.
  assign commitValid  = cfg_commit & ~cfg_shift_en & (bitCount_q == CNT_FULL);
  assign commitBad    = cfg_commit & ~cfg_shift_en & (bitCount_q != CNT_FULL);
  assign isConfigured = (state_q == CONFIGURED);

  for (genvar k = 0; k < P; k++) begin : gTerm
    logic [N-1:0] enables;
    assign enables    = active_q[k*(N+1) +: N];
    assign termRaw[k] = active_q[k*(N+1) + N] & (&(input_signals | ~enables));
  end

  assign sumOut = (|termRaw) ^ active_q[BIT_INVERT];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= UNCONFIGURED;
      shadow_q   <= '0;
      active_q   <= '0;
      bitCount_q <= '0;
      cfgError_q <= 1'b0;
      mcReg_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      bitCount_q <= bitCount_d;
      cfgError_q <= cfgError_d;
      mcReg_q    <= mcReg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (commitValid) begin
      state_d = CONFIGURED;
    end
  end

  // The bit counter sticks at CFG_BITS+1 so an overrun can never alias back to a full load.
  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    bitCount_d = bitCount_q;
    cfgError_d = cfgError_q;
    if (cfg_shift_en) begin
      shadow_d = {cfg_data_in, shadow_q[CFG_BITS-1:1]};
      if (bitCount_q != CNT_OVER) begin
        bitCount_d = bitCount_q + CNT_W'(1);
      end
    end else if (commitValid) begin
      active_d   = shadow_q;
      bitCount_d = '0;
      cfgError_d = 1'b0;
    end else if (commitBad) begin
      cfgError_d = 1'b1;
    end
  end

  always_comb begin
    mcReg_d = mcReg_q;
    if (commitValid) begin
      mcReg_d = 1'b0;
    end else if (clock_enable && isConfigured) begin
      mcReg_d = active_q[BIT_TMODE] ? (mcReg_q ^ sumOut) : sumOut;
    end
  end

  assign cfg_data_out  = shadow_q[0];
  assign configured    = isConfigured;
  assign cfg_error     = cfgError_q;
  assign term_out      = isConfigured ? termRaw : '0;
  assign macrocell_out = isConfigured & (active_q[BIT_BYPASS] ? sumOut : mcReg_q);

endmodule

// File: tb/tb_macrocell_sop.sv
// Directed bench for macrocell_sop with N=4, P=2 (13 configuration bits):
// load, commit, bypass/D/T modes, bad-count commits, shift/commit collision and async reset.
module tb_macrocell_sop;

  logic       clock;
  logic       reset;
  logic       cfg_shift_en;
  logic       cfg_data_in;
  logic       cfg_data_out;
  logic       cfg_commit;
  logic       configured;
  logic       cfg_error;
  logic       clock_enable;
  logic [3:0] input_signals;
  logic [1:0] term_out;
  logic       macrocell_out;

  int passCount = 0;
  int checkCount = 0;

  logic [15:0] cfgWord;

  macrocell_sop #(
    .num_input_signals(4),
    .num_product_terms(2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_shift_en (cfg_shift_en),
    .cfg_data_in  (cfg_data_in),
    .cfg_data_out (cfg_data_out),
    .cfg_commit   (cfg_commit),
    .configured   (configured),
    .cfg_error    (cfg_error),
    .clock_enable (clock_enable),
    .input_signals(input_signals),
    .term_out     (term_out),
    .macrocell_out(macrocell_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic b, input logic commit);
    cfg_shift_en = 1'b1;
    cfg_data_in  = b;
    cfg_commit   = commit;
    tick();
    cfg_shift_en = 1'b0;
    cfg_data_in  = 1'b0;
    cfg_commit   = 1'b0;
  endtask

  task automatic shiftWord(input logic [15:0] w, input int nbits, input logic commitLast);
    for (int i = 0; i < nbits; i++) begin
      applyStimulus(w[i], commitLast && (i == nbits - 1));
    end
  endtask

  task automatic commitPulse();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    cfg_shift_en  = 1'b0;
    cfg_data_in   = 1'b0;
    cfg_commit    = 1'b0;
    clock_enable  = 1'b0;
    input_signals = 4'b0000;
    tick();
    tick();
    checkOutput("rst_configured", configured, 1'b0);
    checkOutput("rst_error", cfg_error, 1'b0);
    checkOutput("rst_dout", cfg_data_out, 1'b0);
    checkOutput("rst_term", term_out, 2'b00);
    checkOutput("rst_out", macrocell_out, 1'b0);
    reset = 1'b0;
    tick();

    // Bypass: term0 = in0 & in1, term1 unallocated.
    shiftWord(16'h1013, 13, 1'b0);
    checkOutput("byp_pre_commit_cfg", configured, 1'b0);
    input_signals = 4'b0011;
    #1;
    checkOutput("byp_unconf_term", term_out, 2'b00);
    checkOutput("byp_unconf_out", macrocell_out, 1'b0);
    commitPulse();
    checkOutput("byp_configured", configured, 1'b1);
    checkOutput("byp_error", cfg_error, 1'b0);
    checkOutput("byp_term_0011", term_out, 2'b01);
    checkOutput("byp_out_0011", macrocell_out, 1'b1);
    input_signals = 4'b0001;
    #1;
    checkOutput("byp_term_0001", term_out, 2'b00);
    checkOutput("byp_out_0001", macrocell_out, 1'b0);

    // D register with invert; shifting must not disturb the running config.
    input_signals = 4'b0011;
    shiftWord(16'h0413, 13, 1'b0);
    checkOutput("shift_keeps_out", macrocell_out, 1'b1);
    commitPulse();
    input_signals = 4'b0001;
    #1;
    checkOutput("d_after_commit", macrocell_out, 1'b0);
    clock_enable = 1'b1;
    tick();
    checkOutput("d_load_1", macrocell_out, 1'b1);
    input_signals = 4'b0011;
    #1;
    checkOutput("d_latency", macrocell_out, 1'b1);
    tick();
    checkOutput("d_load_0", macrocell_out, 1'b0);
    clock_enable  = 1'b0;
    input_signals = 4'b0001;
    tick();
    checkOutput("d_hold", macrocell_out, 1'b0);

    // T mode with an allocated, enable-free term (sum = 1).
    shiftWord(16'h0810, 13, 1'b0);
    commitPulse();
    input_signals = 4'b0000;
    #1;
    checkOutput("t_term", term_out, 2'b01);
    checkOutput("t_start", macrocell_out, 1'b0);
    clock_enable = 1'b1;
    tick();
    checkOutput("t_edge1", macrocell_out, 1'b1);
    tick();
    checkOutput("t_edge2", macrocell_out, 1'b0);
    tick();
    checkOutput("t_edge3", macrocell_out, 1'b1);
    clock_enable = 1'b0;

    // Short load: commit after 12 bits, then finish the word and commit again.
    cfgWord = 16'h1013;
    shiftWord(cfgWord, 12, 1'b0);
    commitPulse();
    checkOutput("short_error", cfg_error, 1'b1);
    checkOutput("short_configured", configured, 1'b1);
    checkOutput("short_term_kept", term_out, 2'b01);
    checkOutput("short_q_kept", macrocell_out, 1'b1);
    applyStimulus(cfgWord[12], 1'b0);
    commitPulse();
    checkOutput("fix_error", cfg_error, 1'b0);
    checkOutput("fix_term_0000", term_out, 2'b00);
    input_signals = 4'b0011;
    #1;
    checkOutput("fix_out_0011", macrocell_out, 1'b1);

    // Commit held together with the 13th shift is ignored; next-cycle commit lands.
    input_signals = 4'b0000;
    shiftWord(16'h0810, 13, 1'b1);
    checkOutput("coll_term_old", term_out, 2'b00);
    checkOutput("coll_error", cfg_error, 1'b0);
    commitPulse();
    checkOutput("coll_commit_term", term_out, 2'b01);
    checkOutput("coll_commit_error", cfg_error, 1'b0);
    checkOutput("coll_commit_out", macrocell_out, 1'b0);

    // Overrun: 14 bits then commit.
    shiftWord(16'h0000, 14, 1'b0);
    commitPulse();
    checkOutput("over_error", cfg_error, 1'b1);
    checkOutput("over_configured", configured, 1'b1);
    checkOutput("over_term_kept", term_out, 2'b01);

    // Async reset in the middle of a shift while q = 1.
    clock_enable = 1'b1;
    tick();
    clock_enable = 1'b0;
    checkOutput("pre_rst_q", macrocell_out, 1'b1);
    shiftWord(16'h001F, 5, 1'b0);
    checkOutput("mid_shift_out", macrocell_out, 1'b1);
    cfg_shift_en = 1'b1;
    cfg_data_in  = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    checkOutput("arst_configured", configured, 1'b0);
    checkOutput("arst_error", cfg_error, 1'b0);
    checkOutput("arst_dout", cfg_data_out, 1'b0);
    checkOutput("arst_term", term_out, 2'b00);
    checkOutput("arst_out", macrocell_out, 1'b0);
    cfg_shift_en = 1'b0;
    cfg_data_in  = 1'b0;
    #1;
    reset = 1'b0;
    tick();
    shiftWord(16'h0001, 12, 1'b0);
    checkOutput("reload_dout_12", cfg_data_out, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("reload_dout_13", cfg_data_out, 1'b1);
    commitPulse();
    checkOutput("reload_configured", configured, 1'b1);
    checkOutput("reload_error", cfg_error, 1'b0);
    input_signals = 4'b0011;
    #1;
    checkOutput("reload_term", term_out, 2'b00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/macrocell_sop.md
MACROCELL_SOP -- requirements
Module: macrocell_sop

Interface
REQ-001 SHALL have parameter num_input_signals, default 88: regional signals per LAB seen by each product term.
REQ-002 SHALL have parameter num_product_terms, default 5: product terms summed by this macrocell.
REQ-003 SHALL use derived constant CFG_BITS = num_product_terms*(num_input_signals+1)+3.
REQ-004 SHALL have port clock, input, 1: single clock; all registers are rising-edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port cfg_shift_en, input, 1: shift one configuration bit this cycle.
REQ-007 SHALL have port cfg_data_in, input, 1: serial configuration data.
REQ-008 SHALL have port cfg_data_out, output, 1: shadow[0], for chaining macrocells.
REQ-009 SHALL have port cfg_commit, input, 1: request to copy shadow into active configuration.
REQ-010 SHALL have port configured, output, 1: active configuration valid.
REQ-011 SHALL have port cfg_error, output, 1: sticky error, set by a commit with a bad bit count.
REQ-012 SHALL have port clock_enable, input, 1: macrocell register enable.
REQ-013 SHALL have port input_signals, input, num_input_signals: logic inputs.
REQ-014 SHALL have port term_out, output, num_product_terms: per-term results, for expander sharing.
REQ-015 SHALL have port macrocell_out, output, 1: macrocell result.

Function
REQ-016 SHALL hold a CFG_BITS shadow register; on cfg_shift_en: shadow <= {cfg_data_in, shadow[CFG_BITS-1:1]}.
REQ-017 SHALL use this shadow layout:
- bit k*(N+1)+i = enable of input i for term k (i<N);
- bit k*(N+1)+N = allocate of term k;
- bit CFG_BITS-3 = invert;
- bit CFG_BITS-2 = t_mode;
- bit CFG_BITS-1 = bypass.
REQ-018 SHALL count shifts in bit_count, which saturates at CFG_BITS+1 (overrun).
REQ-019 SHALL use FSM states UNCONFIGURED and CONFIGURED; configured = (state==CONFIGURED).
REQ-020 SHALL treat cfg_commit with cfg_shift_en low and bit_count==CFG_BITS as a valid commit:
- active <= shadow; state -> CONFIGURED;
- bit_count <= 0; cfg_error <= 0;
- macrocell register q <= 0.
REQ-021 SHALL treat cfg_commit with cfg_shift_en low and bit_count!=CFG_BITS (short or overrun) as an invalid commit:
- cfg_error <= 1;
- active configuration, state and bit_count unchanged.
REQ-022 SHALL give shift precedence when cfg_shift_en and cfg_commit are both high: the shift occurs, the commit is ignored, cfg_error unchanged.
REQ-023 SHALL compute term_out[k] combinationally = allocate_k AND (AND over i of (input_signals[i] OR NOT enable_k,i)); an allocated term with no enables outputs 1; an unallocated term outputs 0.
REQ-024 SHALL define sum = (OR of term_out) XOR invert.
REQ-025 SHALL update q only on clock edges with clock_enable high and state CONFIGURED: t_mode=0 -> q <= sum; t_mode=1 -> q <= q XOR sum.
REQ-026 SHALL drive macrocell_out = bypass ? sum : q, with zero latency in bypass and one-cycle latency in registered mode.
REQ-027 SHALL force term_out = 0 and macrocell_out = 0, and hold q, while UNCONFIGURED.
REQ-028 SHALL leave the active configuration and outputs undisturbed while shifting in CONFIGURED state; reconfiguration takes effect only at a valid commit.

Reset
REQ-029 SHALL, on reset assertion, immediately and asynchronously set: shadow=0, active=0, bit_count=0, q=0, state=UNCONFIGURED, cfg_error=0, configured=0, cfg_data_out=0, term_out=0, macrocell_out=0.
REQ-030 SHALL abandon any shift in progress on reset mid-shift; a full CFG_BITS reload is then required.

Verification (bench parameters N=4, P=2, CFG_BITS=13)
REQ-031 SHALL cover: shift 13 bits setting term0 enables {0,1}, allocate0=1, term1 unallocated, bypass=1, then commit -> configured=1; inputs 4'b0011 -> macrocell_out=1 the same cycle; inputs 4'b0001 -> 0.
REQ-032 SHALL cover: same pattern with bypass=0, t_mode=0, invert=1, inputs 4'b0011, clock_enable=1 -> macrocell_out=0 one cycle later; with clock_enable=0, q holds.
REQ-033 SHALL cover: T mode, term0 allocated with no enables (sum=1) -> macrocell_out toggles 0,1,0,1 on successive enabled edges.
REQ-034 SHALL cover: commit after 12 shifts, and commit after 14 shifts -> cfg_error=1, configured unchanged; a following correct 13-bit load plus commit -> cfg_error=0.
REQ-035 SHALL cover: cfg_shift_en and cfg_commit high together on the 13th shift -> no commit; commit on the next cycle succeeds.
REQ-036 SHALL cover: reset asserted mid-shift and while q=1 -> all outputs 0 without waiting for a clock edge; cfg_data_out after 13 further shifts equals the first bit shifted in.
